// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encodings and small decode helpers.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_t;

    // Bit 1 of the op code selects divide, bit 0 selects signed.
    function automatic logic op_is_div(input mdu_op_t o);
        return o[1];
    endfunction

    function automatic logic op_is_signed(input mdu_op_t o);
        return o[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide engine, purely combinational.
// Multiply: shift-add, LSB-first; the accumulator shifts right and the new
//           partial sum enters at the top.
// Divide:   restoring shift-subtract, MSB-first; the upper half holds the
//           partial remainder and quotient bits shift into the lower half.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int wide = 32
) (
    input  logic              is_div,
    input  logic [2*wide-1:0] acc,
    input  logic [wide-1:0]   operand,
    input  logic              bit_in,
    output logic [2*wide-1:0] acc_next
);

    logic [wide:0]   mul_sum;
    logic [wide:0]   rem_shift;
    logic            rem_ge;
    logic [wide-1:0] rem_sub;

    // Compute both candidate next-accumulators and select by mode.
    always_comb begin
        mul_sum   = {1'b0, acc[2*wide-1:wide]} + (bit_in ? {1'b0, operand} : '0);
        rem_shift = {acc[2*wide-1:wide], bit_in};
        rem_ge    = (rem_shift >= {1'b0, operand});
        // When the subtract succeeds the true difference is below the divisor,
        // so the low bits alone carry it exactly.
        rem_sub   = rem_shift[wide-1:0] - operand;
        acc_next  = '0;
        if (is_div) begin
            if (rem_ge) begin
                acc_next = {rem_sub, acc[wide-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[wide-1:0], acc[wide-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[wide-1:1]};
        end
    end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// IDLE accepts an issue (or an MTHI/MTLO write), RUN performs exactly `wide`
// iterations, FIX applies sign correction and writes HI/LO, then a one-cycle
// done pulse is raised back in IDLE.
module mdu
    import mdu_pkg::*;
#(
    parameter int wide = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [wide-1:0] a,
    input  logic [wide-1:0] b,
    input  logic            we_hi,
    input  logic            we_lo,
    input  logic [wide-1:0] wd,
    output logic            busy,
    output logic            done,
    output logic [wide-1:0] hi,
    output logic [wide-1:0] lo
);

    localparam int              CNT_W    = (wide > 1) ? $clog2(wide) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(wide - 1);

    mdu_state_t        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    mdu_op_t           op_reg;
    logic              neg_q_reg;      // product sign, or quotient sign
    logic              neg_r_reg;      // remainder sign (sign of dividend)
    logic              div_zero_reg;   // divide with a zero divisor
    logic [2*wide-1:0] acc_reg;
    logic [wide-1:0]   src_reg;        // multiplier / dividend, consumed one bit per cycle
    logic [wide-1:0]   opd_reg;        // multiplicand / divisor
    logic [wide-1:0]   hi_reg;
    logic [wide-1:0]   lo_reg;
    logic              busy_reg;
    logic              done_reg;

    mdu_op_t           op_in;
    logic              sgn_in;
    logic              a_neg;
    logic              b_neg;
    logic [wide-1:0]   a_mag;
    logic [wide-1:0]   b_mag;

    logic              step_bit;
    logic [2*wide-1:0] acc_next;

    logic [2*wide-1:0] prod_fix;
    logic [wide-1:0]   quo_fix;
    logic [wide-1:0]   rem_fix;
    logic [wide-1:0]   fix_hi;
    logic [wide-1:0]   fix_lo;

    // Accept-time operand conditioning: magnitudes and signs for signed ops.
    always_comb begin
        op_in  = mdu_op_t'(op);
        sgn_in = op_is_signed(op_in);
        a_neg  = sgn_in & a[wide-1];
        b_neg  = sgn_in & b[wide-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
    end

    // Multiply consumes the multiplier LSB-first, divide the dividend MSB-first.
    always_comb begin
        step_bit = op_is_div(op_reg) ? src_reg[wide-1] : src_reg[0];
    end

    mdu_step #(
        .wide(wide)
    ) u_step (
        .is_div   (op_is_div(op_reg)),
        .acc      (acc_reg),
        .operand  (opd_reg),
        .bit_in   (step_bit),
        .acc_next (acc_next)
    );

    // Sign correction of the finished unsigned result.
    always_comb begin
        prod_fix = (op_is_signed(op_reg) & neg_q_reg) ? -acc_reg : acc_reg;
        quo_fix  = (op_is_signed(op_reg) & neg_q_reg) ? -acc_reg[wide-1:0] : acc_reg[wide-1:0];
        rem_fix  = (op_is_signed(op_reg) & neg_r_reg) ? -acc_reg[2*wide-1:wide]
                                                      : acc_reg[2*wide-1:wide];
        if (op_is_div(op_reg)) begin
            // A zero divisor leaves the remainder equal to |a|; restoring the
            // dividend sign reproduces the raw dividend for DIV as well.
            fix_hi = rem_fix;
            fix_lo = div_zero_reg ? '1 : quo_fix;
        end else begin
            fix_hi = prod_fix[2*wide-1:wide];
            fix_lo = prod_fix[wide-1:0];
        end
    end

    // Control FSM, datapath registers and HI/LO, all with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            op_reg       <= MDU_MULTU;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            acc_reg      <= '0;
            src_reg      <= '0;
            opd_reg      <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= RUN;
                        busy_reg     <= 1'b1;
                        cnt_reg      <= CNT_LOAD;
                        op_reg       <= op_in;
                        neg_q_reg    <= a_neg ^ b_neg;
                        neg_r_reg    <= a_neg;
                        div_zero_reg <= op_is_div(op_in) & (b == '0);
                        acc_reg      <= '0;
                        src_reg      <= a_mag;
                        opd_reg      <= b_mag;
                        // Multiply iterates over b, so swap roles for it.
                        if (!op_is_div(op_in)) begin
                            src_reg <= b_mag;
                            opd_reg <= a_mag;
                        end
                    end else begin
                        if (we_hi) hi_reg <= wd;
                        if (we_lo) lo_reg <= wd;
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    if (op_is_div(op_reg)) begin
                        src_reg <= {src_reg[wide-2:0], 1'b0};
                    end else begin
                        src_reg <= {1'b0, src_reg[wide-1:1]};
                    end
                    if (cnt_reg == '0) begin
                        state_reg <= FIX;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                FIX: begin
                    hi_reg    <= fix_hi;
                    lo_reg    <= fix_lo;
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO and accept cycle,
// a monitor pops and compares on every done pulse.
module tb_mdu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu #(.wide(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endfunction

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL spurious_done: got done=1 expected no done (hi=0x%0h lo=0x%0h)", hi, lo);
            end else begin
                mon_e = sb.pop_front();
                $display("done  %s hi=0x%08h lo=0x%08h latency=%0d", mon_e.name, hi, lo, cyc - mon_e.acc_cyc);
                check({mon_e.name, "_hi"}, {32'd0, hi}, {32'd0, mon_e.hi});
                check({mon_e.name, "_lo"}, {32'd0, lo}, {32'd0, mon_e.lo});
                check({mon_e.name, "_latency"}, 64'(cyc - mon_e.acc_cyc), 64'd33);
                check({mon_e.name, "_busy_in_done"}, {63'd0, busy}, 64'd0);
            end
        end
    end

    // Drive an issue right after a falling edge and register the expectation.
    task automatic drive_and_accept(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                                    input logic [31:0] eh, input logic [31:0] el, input string nm);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start   = 1'b0;
        e.hi      = eh;
        e.lo      = el;
        e.acc_cyc = cyc;
        e.name    = nm;
        sb.push_back(e);
        $display("issue %s op=%0d a=0x%08h b=0x%08h", nm, o, av, bv);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el, input string nm);
        @(negedge clk);
        drive_and_accept(o, av, bv, eh, el, nm);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done_cycle(input string nm);
        int n = 0;
        @(negedge clk);
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            $display("FAIL %s_wait: got no done expected done within 60 cycles", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        we_hi = 1'b0;
        we_lo = 1'b0;
        wd    = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        rst = 1'b1;

        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        drain();
        issue(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5");
        drain();
        issue(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2");
        drain();
        issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100by7");
        drain();
        issue(2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, "divu_by_zero");
        drain();
        issue(2'b11, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by_zero");
        drain();
        issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow");
        drain();

        // MTHI, MTLO, and both together.
        we_hi = 1'b1; wd = 32'h1234;
        @(negedge clk);
        we_hi = 1'b0;
        $display("mthi  wd=0x1234 hi=0x%08h lo=0x%08h", hi, lo);
        check("mthi_hi", {32'd0, hi}, 64'h1234);
        check("mthi_lo_kept", {32'd0, lo}, 64'h80000000);
        we_lo = 1'b1; wd = 32'h5678;
        @(negedge clk);
        we_lo = 1'b0;
        $display("mtlo  wd=0x5678 hi=0x%08h lo=0x%08h", hi, lo);
        check("mtlo_lo", {32'd0, lo}, 64'h5678);
        check("mtlo_hi_kept", {32'd0, hi}, 64'h1234);
        we_hi = 1'b1; we_lo = 1'b1; wd = 32'hABCD;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0;
        $display("mthilo wd=0xabcd hi=0x%08h lo=0x%08h", hi, lo);
        check("mthilo_hi", {32'd0, hi}, 64'hABCD);
        check("mthilo_lo", {32'd0, lo}, 64'hABCD);

        // MTHI in the same cycle as an accepted start is dropped.
        @(negedge clk);
        we_hi = 1'b1; wd = 32'hFFFF;
        drive_and_accept(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, "multu_2x3_with_mthi");
        we_hi = 1'b0;
        check("start_beats_mthi_hi", {32'd0, hi}, 64'hABCD);
        check("start_busy", {63'd0, busy}, 64'd1);
        drain();

        // MTLO and a second start during RUN are ignored; HI/LO stay put.
        issue(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, "multu_6x7");
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd1; b = 32'd1;
        we_lo = 1'b1; wd = 32'hDEAD;
        @(posedge clk);
        #1;
        $display("run   ignored start+mtlo hi=0x%08h lo=0x%08h busy=%0d", hi, lo, busy);
        check("run_busy", {63'd0, busy}, 64'd1);
        check("run_lo_stable", {32'd0, lo}, 64'd6);
        check("run_hi_stable", {32'd0, hi}, 64'd0);
        @(negedge clk);
        start = 1'b0; we_lo = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Back-to-back issue in the done cycle.
        issue(2'b10, 32'd1000, 32'd10, 32'd0, 32'd100, "divu_1000by10");
        wait_done_cycle("b2b");
        drive_and_accept(2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, "div_7byneg2_b2b");
        check("b2b_busy", {63'd0, busy}, 64'd1);
        drain();
        issue(2'b01, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, "mult_max_by_neg1");
        drain();

        // Asynchronous reset in the middle of a multiply.
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_aborted");
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        $display("reset mid-run busy=%0d done=%0d hi=0x%08h lo=0x%08h", busy, done, hi, lo);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("post_reset_busy", {63'd0, busy}, 64'd0);
        check("post_reset_lo", {32'd0, lo}, 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the MIPS datapath. It replaces the combinational `multi` path with a multi-cycle engine that owns the HI/LO registers. The engine executes MULT, MULTU, DIV and DIVU, and accepts MTHI/MTLO writes. It sits beside the ALU: operands come from regfile `rd1`/`rd2`, issue strobes come from `auxdec` decode, and `hi`/`lo` feed the MFHI/MFLO writeback mux. The core stalls on `busy`.

## Interface
- `wide`, default 32: operand width. HI and LO are each `wide` bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous assert, active-low, synchronous release.
- `start`  in  1  issue strobe; sampled only when `busy`=0.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  `wide`  rs operand (multiplicand or dividend).
- `b`  in  `wide`  rt operand (multiplier or divisor).
- `we_hi`  in  1  MTHI write strobe.
- `we_lo`  in  1  MTLO write strobe.
- `wd`  in  `wide`  MTHI/MTLO write data.
- `busy`  out  1  operation in flight; the core must stall MFHI, MFLO, MTHI, MTLO and new issues while it is high.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- `hi`  out  `wide`  HI register (product upper half / remainder).
- `lo`  out  `wide`  LO register (product lower half / quotient).

## Operation
- FSM states:
  - IDLE → RUN on `start`.
  - RUN holds for exactly `wide` iterations, counted by a down-counter loaded with `wide`-1.
  - RUN → FIX when the counter reaches 0.
  - FIX → IDLE unconditionally.
- Accept (IDLE & `start`):
  - Latch `op`.
  - For signed ops, latch |a| and |b| plus the result sign(s); otherwise latch the raw operands.
  - Clear the 2·`wide` accumulator.
- Multiply: one iteration per cycle. Shift-add, LSB-first over the multiplier, producing a 2·`wide` unsigned product.
- Divide: one iteration per cycle. Restoring shift-subtract, MSB-first, producing a `wide` quotient and a `wide` remainder.
- FIX writes HI/LO:
  - MULT: if the product is negative, write the two's-complement of the full 2·`wide` product.
  - DIV: quotient takes sign(a) XOR sign(b); remainder takes sign(a).
  - Then `hi` = upper half / remainder, `lo` = lower half / quotient.
- Divide by zero: no exception, same latency. Result `lo` = all ones, `hi` = a (raw dividend, for both DIV and DIVU).
- Signed overflow: DIV of 0x80000000 by 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. The result wraps and no trap is raised.
- MTHI/MTLO:
  - Honoured only in IDLE with `start`=0; the write lands at the next edge.
  - `we_hi` and `we_lo` may assert together and write the same `wd` to both registers.
  - Ignored while `busy`=1.
  - Ignored in a cycle where `start` is accepted; `start` has priority.
- `start` while `busy`=1 is ignored. No queueing.
- Reset (`rst`=0, at any time, including mid-RUN or FIX):
  - State returns to IDLE.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
  - No partial result is written.

## Timing
- `start` is accepted at edge E0. `busy` is high from E0 through E`wide`+1 and is low after E`wide`+1.
- HI/LO update at edge E`wide`+1 (FIX). `done`=1 for the single cycle after that edge, with `busy`=0 in that cycle.
- Latency: `done` is asserted `wide`+1 cycles after the accept edge, i.e. 33 for `wide`=32. This is independent of op and operand values; there is no early termination.
- Back-to-back issue is allowed. A `start` in the `done` cycle is accepted, so issue interval is `wide`+2 cycles.
- `hi`/`lo` are register outputs with no combinational path from inputs. They are stable throughout RUN and hold the previous result until FIX.

## Structure
- Shared package holds:
  - op encodings: `MDU_MULTU`=2'b00, `MDU_MULT`=2'b01, `MDU_DIVU`=2'b10, `MDU_DIV`=2'b11.
  - FSM state encodings: IDLE, RUN, FIX.
- One sub-module, `mdu_step`: combinational single iteration. Inputs are the mode (mul/div), accumulator, operand and the current multiplier/quotient bit; it returns the next accumulator. The top level holds the FSM, counter, sign latches, FIX correction and the HI/LO registers.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `done` 33 cycles after accept, `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT a=0xFFFFFFFD (−3), b=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Then DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU a=100, b=7 → `lo`=14, `hi`=2. Then DIVU a=5, b=0 → `lo`=0xFFFFFFFF, `hi`=5, still 33 cycles.
- DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI `wd`=0x1234 in IDLE → `hi`=0x1234 next cycle. MTLO and a second `start` issued during RUN → both ignored, and the original result appears. A new `start` in the `done` cycle is accepted and `busy` stays asserted.
- Assert `rst`=0 asynchronously 10 cycles into a MULTU → `busy`, `done`, `hi`, `lo` all 0 immediately. After release, no `done` pulse occurs without a new `start`.
